alu_md: RTL
===========

# alu_md

Parametrised, multi-cycle successor to the pipeline's single-cycle ALU. Executes the logical, arithmetic and compare operations in one registered cycle. Also executes MIPS MULT/MULTU/DIV/DIVU iteratively into internal HI/LO registers, and provides MFHI/MFLO reads. Sits in the EX stage of the pipelined MIPS core; the hazard unit stalls issue while `in_ready` is low.

## Interface
- `W`, 32: datapath width; even, at least 8.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  high iff state is IDLE; accept = `in_valid & in_ready` at a rising edge.
- `ctl`  in  4  opcode, sampled on accept.
- `a`, `b`  in  W  operands, sampled on accept.
- `out_valid`  out  1  one-cycle completion pulse.
- `result`  out  W  registered result; held until next completion.
- `zero`  out  1  `result == 0`, registered with `result`.
- `overflow`  out  1  signed overflow of ADD/SUB; 0 for all other ops.
- `illegal`  out  1  unsupported `ctl` at the completing op.
- `hi`, `lo`  out  W  HI/LO register contents.

## Operation
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 NOR; 0100 XOR; 0101 SLTU (unsigned); 0110 SUB; 0111 SLT (signed).
  - 1000 MULT; 1001 MULTU; 1010 DIV; 1011 DIVU.
  - 1100 MFHI; 1101 MFLO.
  - All other codes are illegal.
- ADD/SUB wrap modulo 2^W.
  - `overflow` = operand signs match (ADD) or differ (SUB) and the result sign differs from `a`.
- SLT/SLTU: `result` = 1 or 0.
- Illegal op: `result` = 0, `zero` = 1, `illegal` = 1. HI/LO unchanged. Completes like a single-cycle op.
- States:
  - IDLE: an accept of a single-cycle op stays in IDLE. MULT/MULTU go to MUL; DIV/DIVU go to DIV.
  - MUL/DIV: shift-add multiply or restoring divide, one bit per cycle, W cycles, on magnitudes. Sign correction is applied on the last cycle. Then return to IDLE.
- Multiply: {HI,LO} = full 2W-bit product. Signed for MULT, unsigned for MULTU.
- Divide:
  - LO = quotient, truncated toward zero. HI = remainder, with the sign of the dividend.
  - Divide by zero: HI = `a`, LO = all ones. No error flag.
  - DIV of most-negative by −1: LO = most-negative, HI = 0.
- MULT/DIV completion: `result` = new LO, `zero` from LO, `overflow` = 0.
- MFHI/MFLO return the current HI/LO. An MFHI/MFLO issued on the cycle after a MULT/DIV completion sees the new values.
- `in_valid` while busy is ignored. There is no output backpressure.

## Timing
- Reset (`reset_n` low, asynchronous): state IDLE; `result`, `hi`, `lo` = 0; `zero` = 0; `out_valid`, `overflow`, `illegal` = 0; `in_ready` = 1.
- Reset mid-MUL/DIV: the operation is aborted. No `out_valid`, HI/LO cleared.
- Single-cycle op accepted at edge E0:
  - `result` and flags update at E0; `out_valid` high for the cycle after E0.
  - Back-to-back accepts every cycle give continuous `out_valid`.
- MUL/DIV accepted at E0:
  - `in_ready` low after E0 through edge E0+W.
  - HI/LO/`result` update at E0+W; `out_valid` high for the cycle after E0+W.
  - `in_ready` high again after E0+W.
- Iteration counter: ceil(log2 W) bits, counts W−1 down to 0.

## Configuration
- `ALU_MD_DIV_EN` defined: DIV/DIVU are implemented as above.
- `ALU_MD_DIV_EN` undefined:
  - No divider hardware.
  - 1010/1011 are illegal: single-cycle completion, `illegal` = 1, `result` = 0, HI/LO unchanged.
  - MUL path unaffected.

## Test plan
- ADD, W=32, a=0x7FFFFFFF, b=1 -> one cycle later `out_valid`=1, `result`=0x80000000, `overflow`=1, `zero`=0.
- SUB a=b=0x1234 -> `result`=0, `zero`=1, `overflow`=0. Then SLT a=0xFFFFFFFF, b=0 -> `result`=1; SLTU with the same operands -> `result`=0.
- MULT a=−3, b=5 -> `in_ready` low for 32 cycles; completion pulse after edge E0+32 with `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. Next-cycle MFHI -> `result`=0xFFFFFFFF.
- DIV a=−7, b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU a=9, b=0 -> `hi`=9, `lo`=0xFFFFFFFF. Without `ALU_MD_DIV_EN`, DIV -> `illegal`=1 after one cycle, HI/LO unchanged.
- Assert `reset_n` low 10 cycles into a MULTU -> immediate IDLE, `hi`/`lo`=0, no `out_valid`. A new ADD is accepted on the first edge after release.
- `ctl`=1111 -> `illegal`=1, `result`=0, `zero`=1. The following valid op clears `illegal`.

Source files
------------

// File: rtl/alu_md.sv
// alu_md: multi-cycle ALU for the EX stage of the pipelined MIPS core.
//
// Single-cycle ops (AND/OR/ADD/NOR/XOR/SLTU/SUB/SLT/MFHI/MFLO) complete
// on the edge that accepts them. MULT/MULTU run a shift-add multiplier and
// DIV/DIVU run a restoring divider, one bit per cycle for W cycles, on
// operand magnitudes; the sign fix-up is folded into the last iteration.
// The results land in the HI/LO registers.
//
// Build option: define ALU_MD_DIV_EN to include the divider. Without it,
// DIV/DIVU (1010/1011) are illegal opcodes that complete in one cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   operation request
//   in_ready   high while idle; accept = in_valid & in_ready at an edge
//   ctl[3:0]   opcode, sampled on accept
//   a, b       operands, sampled on accept
//   out_valid  one-cycle completion pulse
//   result     registered result, held until the next completion
//   zero       result == 0, registered with result
//   overflow   signed overflow of ADD/SUB, 0 otherwise
//   illegal    unsupported opcode at the completing op
//   hi, lo     HI/LO register contents
module alu_md #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   ctl,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  output logic [W-1:0] result,
  output logic         zero,
  output logic         overflow,
  output logic         illegal,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int            CW       = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MFHI = 4'b1100;
  localparam logic [3:0] OP_MFLO = 4'b1101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t state, state_nx;

  logic          accept;
  logic          is_mul;
  logic          is_div;
  logic [CW-1:0] cnt;

  // Iteration registers shared by multiplier and divider:
  //   multiply: acc_hi = partial product high half, acc_lo = multiplier
  //             shifting out / product low half shifting in
  //   divide:   acc_hi = partial remainder, acc_lo = dividend shifting
  //             out / quotient shifting in
  logic [W-1:0]  opnd;
  logic [W-1:0]  acc_hi;
  logic [W-1:0]  acc_lo;
  logic          neg_lo;   // negate the product / quotient at the end

  logic          sa;
  logic          sb;
  logic [W-1:0]  mag_a;
  logic [W-1:0]  mag_b;

  logic [W-1:0]  sum;
  logic [W-1:0]  diff;
  logic [W-1:0]  sc_res;
  logic          sc_ovf;
  logic          sc_ill;

  logic [W:0]    msum;
  logic [W-1:0]  mul_hi_nx;
  logic [W-1:0]  mul_lo_nx;
  logic [2*W-1:0] prod;
  logic [2*W-1:0] prod_fin;

`ifdef ALU_MD_DIV_EN
  logic          neg_hi;   // remainder takes the dividend's sign
  logic          dz;       // divisor was zero
  logic [W:0]    dshift;
  logic          dge;
  logic [W-1:0]  dtrial;
  logic [W-1:0]  div_hi_nx;
  logic [W-1:0]  div_lo_nx;
  logic [W-1:0]  q_fin;
  logic [W-1:0]  r_fin;
`endif

  assign in_ready = (state == S_IDLE);
  assign accept   = in_valid & in_ready;
  assign is_mul   = (ctl[3:1] == 3'b100);
`ifdef ALU_MD_DIV_EN
  assign is_div   = (ctl[3:1] == 3'b101);
`else
  assign is_div   = 1'b0;
`endif

  // ctl[0] = 0 selects the signed variant (MULT, DIV).
  assign sa    = ~ctl[0] & a[W-1];
  assign sb    = ~ctl[0] & b[W-1];
  assign mag_a = sa ? -a : a;
  assign mag_b = sb ? -b : b;

  assign sum  = a + b;
  assign diff = a - b;

  // NOTE: every variable assigned in an always_comb gets a default first so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    sc_res = '0;
    sc_ovf = 1'b0;
    sc_ill = 1'b0;
    case (ctl)
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_NOR:  sc_res = ~(a | b);
      OP_XOR:  sc_res = a ^ b;
      OP_SLTU: sc_res = {{(W-1){1'b0}}, (a < b)};
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_SLT:  sc_res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_MFHI: sc_res = hi;
      OP_MFLO: sc_res = lo;
      default: sc_ill = 1'b1;
    endcase
  end

  // Shift-add step: add the multiplicand when the multiplier LSB is set,
  // then shift the whole {carry, acc_hi, acc_lo} right by one.
  assign msum      = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  assign mul_hi_nx = msum[W:1];
  assign mul_lo_nx = {msum[0], acc_lo[W-1:1]};
  assign prod      = {mul_hi_nx, mul_lo_nx};
  assign prod_fin  = neg_lo ? -prod : prod;

`ifdef ALU_MD_DIV_EN
  // Restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits. The difference is below the divisor,
  // so W bits hold it.
  assign dshift    = {acc_hi, acc_lo[W-1]};
  assign dge       = (dshift >= {1'b0, opnd});
  assign dtrial    = dshift[W-1:0] - opnd;
  assign div_hi_nx = dge ? dtrial : dshift[W-1:0];
  assign div_lo_nx = {acc_lo[W-2:0], dge};
  // With a zero divisor every step "fits", so the remainder ends up as the
  // dividend magnitude and the sign fix-up restores a; only LO is forced.
  assign q_fin     = dz ? '1 : (neg_lo ? -div_lo_nx : div_lo_nx);
  assign r_fin     = neg_hi ? -div_hi_nx : div_hi_nx;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_mul)      state_nx = S_MUL;
          else if (is_div) state_nx = S_DIV;
        end
      end
      S_MUL, S_DIV: if (cnt == '0) state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // NOTE: the iteration registers are reset along with the architectural
  // ones; a reset mid-operation must leave no stale partial result behind.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      opnd      <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      neg_lo    <= 1'b0;
`ifdef ALU_MD_DIV_EN
      neg_hi    <= 1'b0;
      dz        <= 1'b0;
`endif
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (is_mul || is_div) begin
              opnd   <= mag_b;
              acc_hi <= '0;
              acc_lo <= mag_a;
              neg_lo <= sa ^ sb;
              cnt    <= CNT_LAST;
`ifdef ALU_MD_DIV_EN
              neg_hi <= sa;
              dz     <= (b == '0);
`endif
            end else begin
              result    <= sc_res;
              zero      <= (sc_res == '0);
              overflow  <= sc_ovf;
              illegal   <= sc_ill;
              out_valid <= 1'b1;
            end
          end
        end
        S_MUL: begin
          acc_hi <= mul_hi_nx;
          acc_lo <= mul_lo_nx;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            hi        <= prod_fin[2*W-1:W];
            lo        <= prod_fin[W-1:0];
            result    <= prod_fin[W-1:0];
            zero      <= (prod_fin[W-1:0] == '0);
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
          end
        end
`ifdef ALU_MD_DIV_EN
        S_DIV: begin
          acc_hi <= div_hi_nx;
          acc_lo <= div_lo_nx;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            hi        <= r_fin;
            lo        <= q_fin;
            result    <= q_fin;
            zero      <= (q_fin == '0);
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
